// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute and decodes datapath controls from state.
// Define INSTRET_COUNTER_EN to build the retired-instruction counter; otherwise instret is tied to 0.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic        funct3b0,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] TRAP     = 4'd11;

    logic [3:0] state_reg;
    logic [3:0] state_next;

    logic pc_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic mem_write_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:    if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_next = MEMADR;
                    7'b0110011:             state_next = EXECUTER;
                    7'b0010011:             state_next = EXECUTEI;
                    7'b1100011:             state_next = BRANCH;
                    7'b1101111:             state_next = JAL;
                    default:                state_next = TRAP;
                endcase
            end
            MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: if (mem_ready) state_next = FETCH;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JAL:      state_next = ALUWB;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        illegal       = 1'b0;
        case (state_reg)
            FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB:    reg_write_raw = 1'b1;
            BRANCH: begin
                ALUSrcA      = 2'b10;
                ALUOp        = 2'b01;
                pc_write_raw = zero ^ funct3b0;
            end
            JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
            end
            TRAP:     illegal = 1'b1;
            default:  illegal = 1'b0;
        endcase
    end

    // Reset kills write enables immediately so an abandoned instruction cannot commit anything.
    assign PCWrite  = pc_write_raw  & ~reset;
    assign IRWrite  = ir_write_raw  & ~reset;
    assign RegWrite = reg_write_raw & ~reset;
    assign MemWrite = mem_write_raw & ~reset;
    assign state    = state_reg;

`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret_reg;
    logic        retire;

    assign retire = (state_reg == MEMWB) || (state_reg == ALUWB) || (state_reg == BRANCH) ||
                    ((state_reg == MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_reg <= 32'd0;
        end else if (retire) begin
            instret_reg <= instret_reg + 32'd1;
        end
    end

    assign instret = instret_reg;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic        funct3b0;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] instret;
    logic [13:0] obs_ctrl;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef INSTRET_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
    localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;
    localparam int S_JAL = 10, S_TRAP = 11;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3b0  (funct3b0),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .illegal   (illegal),
        .state     (state),
        .instret   (instret)
    );

    assign obs_ctrl = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Control table straight from the per-state output listing.
    function automatic logic [13:0] exp_ctrl(input int s, input logic mr, input logic z,
                                             input logic f3, input logic rst);
        logic pcw, irw, rw, mw, adr, ill;
        logic [1:0] res, a, b, aop;
        pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; ill = 0;
        res = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        case (s)
            S_FETCH:    begin b = 2'b10; res = 2'b10; pcw = mr; irw = mr; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMREAD:  adr = 1;
            S_MEMWB:    begin res = 2'b01; rw = 1; end
            S_MEMWRITE: begin adr = 1; mw = 1; end
            S_EXECR:    begin a = 2'b10; aop = 2'b10; end
            S_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            S_ALUWB:    rw = 1;
            S_BRANCH:   begin a = 2'b10; aop = 2'b01; pcw = z ^ f3; end
            S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
            S_TRAP:     ill = 1;
            default:    ill = 0;
        endcase
        if (rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
        return {pcw, irw, rw, mw, adr, res, a, b, aop, ill};
    endfunction

    // Inputs given here are those applied during the cycle observed at the following negedge.
    task automatic tick(input logic r, input logic [6:0] o, input logic f, input logic z, input logic m);
        @(posedge clk);
        #1;
        reset = r; op = o; funct3b0 = f; zero = z; mem_ready = m;
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b1, OP_R, 1'b0, 1'b0, 1'b1);
        tick(1'b1, OP_R, 1'b0, 1'b0, 1'b1);
    endtask

    int   q_state[$];
    logic q_mr[$];

    task automatic push_state(input int s, input int stalls);
        if (stalls < 0) begin
            q_state.push_back(s);
            q_mr.push_back(1'($urandom_range(0, 1)));
        end else begin
            for (int i = 0; i < stalls; i++) begin
                q_state.push_back(s);
                q_mr.push_back(1'b0);
            end
            q_state.push_back(s);
            q_mr.push_back(1'b1);
        end
    endtask

    // Instruction-level model: state path by instruction class, stretched by chosen memory stalls.
    task automatic plan_instr(input logic [6:0] o);
        q_state.delete();
        q_mr.delete();
        push_state(S_FETCH, $urandom_range(0, 2));
        push_state(S_DECODE, -1);
        case (o)
            OP_LW:   begin push_state(S_MEMADR, -1); push_state(S_MEMREAD, $urandom_range(0, 3));
                           push_state(S_MEMWB, -1); end
            OP_SW:   begin push_state(S_MEMADR, -1); push_state(S_MEMWRITE, $urandom_range(0, 3)); end
            OP_R:    begin push_state(S_EXECR, -1); push_state(S_ALUWB, -1); end
            OP_I:    begin push_state(S_EXECI, -1); push_state(S_ALUWB, -1); end
            OP_B:    push_state(S_BRANCH, -1);
            OP_JAL:  begin push_state(S_JAL, -1); push_state(S_ALUWB, -1); end
            default: push_state(S_TRAP, -1);
        endcase
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d, required 0", state);
        end
        n_cmp++;
        if (obs_ctrl !== exp_ctrl(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b1)) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, required %b", obs_ctrl, exp_ctrl(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b1));
        end
        n_cmp++;
        if (instret !== 32'd0) begin
            n_fail++; $display("FAIL reset_instret: got %0d, required 0", instret);
        end
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs_ctrl !== exp_ctrl(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL fetch_after_reset: got %b, required %b", obs_ctrl, exp_ctrl(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        $display("test_reset done");
    endtask

    task automatic test_rtype();
        int exp_s[5] = '{0, 1, 6, 8, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, OP_R, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (state !== 4'(exp_s[i])) begin
                n_fail++; $display("FAIL rtype_state[%0d]: got %0d, required %0d", i + 1, state, exp_s[i]);
            end
            n_cmp++;
            if (RegWrite !== (i == 3) || ALUOp !== ((i == 2) ? 2'b10 : 2'b00)) begin
                n_fail++; $display("FAIL rtype_ctrl[%0d]: got RegWrite=%b ALUOp=%b, required RegWrite=%b ALUOp=%b",
                                   i + 1, RegWrite, ALUOp, (i == 3), ((i == 2) ? 2'b10 : 2'b00));
            end
        end
        $display("test_rtype done");
    endtask

    task automatic test_lw_stall();
        int   exp_s[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
        logic mr[8]    = '{1, 1, 1, 0, 0, 1, 1, 0};
        int   rw_count = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, OP_LW, 1'b0, 1'b0, mr[i]);
            if (RegWrite === 1'b1) rw_count++;
            n_cmp++;
            if (state !== 4'(exp_s[i])) begin
                n_fail++; $display("FAIL lw_state[%0d]: got %0d, required %0d", i + 1, state, exp_s[i]);
            end
        end
        n_cmp++;
        if (rw_count != 1) begin
            n_fail++; $display("FAIL lw_regwrite_count: got %0d, required 1", rw_count);
        end
        $display("test_lw_stall done");
    endtask

    task automatic test_branch();
        for (int k = 0; k < 4; k++) begin
            logic f3, z;
            f3 = k[1];
            z  = k[0];
            do_reset();
            tick(1'b0, OP_B, f3, z, 1'b1);
            tick(1'b0, OP_B, f3, z, 1'b1);
            tick(1'b0, OP_B, f3, z, 1'b1);
            n_cmp++;
            if (state !== 4'd9 || PCWrite !== (z ^ f3)) begin
                n_fail++; $display("FAIL branch_f3_%0d_z_%0d: got state=%0d PCWrite=%b, required state=9 PCWrite=%b",
                                   f3, z, state, PCWrite, z ^ f3);
            end
            tick(1'b0, OP_B, f3, z, 1'b0);
            n_cmp++;
            if (state !== 4'd0) begin
                n_fail++; $display("FAIL branch_return: got %0d, required 0", state);
            end
        end
        $display("test_branch done");
    endtask

    task automatic test_trap();
        do_reset();
        tick(1'b0, 7'b0000000, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 7'b0000000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (state !== 4'd1) begin
            n_fail++; $display("FAIL trap_decode: got %0d, required 1", state);
        end
        for (int i = 0; i < 10; i++) begin
            logic m, z;
            m = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            tick(1'b0, OP_R, 1'b0, z, m);
            n_cmp++;
            if (state !== 4'd11 || obs_ctrl !== exp_ctrl(S_TRAP, m, z, 1'b0, 1'b0)) begin
                n_fail++; $display("FAIL trap_hold[%0d]: got state=%0d ctrl=%b, required state=11 ctrl=%b",
                                   i, state, obs_ctrl, exp_ctrl(S_TRAP, m, z, 1'b0, 1'b0));
            end
        end
        tick(1'b1, OP_R, 1'b0, 1'b0, 1'b0);
        tick(1'b1, OP_R, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL trap_reset: got state=%0d illegal=%b, required state=0 illegal=0", state, illegal);
        end
        $display("test_trap done");
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        tick(1'b0, OP_SW, 1'b0, 1'b0, 1'b1);
        tick(1'b0, OP_SW, 1'b0, 1'b0, 1'b1);
        tick(1'b0, OP_SW, 1'b0, 1'b0, 1'b1);
        tick(1'b0, OP_SW, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            n_fail++; $display("FAIL sw_stall: got state=%0d MemWrite=%b, required state=5 MemWrite=1", state, MemWrite);
        end
        tick(1'b1, OP_SW, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (MemWrite !== 1'b0 || obs_ctrl !== exp_ctrl(S_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_fail++; $display("FAIL sw_reset_cycle: got ctrl=%b, required ctrl=%b",
                               obs_ctrl, exp_ctrl(S_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        tick(1'b0, OP_SW, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (state !== 4'd0 || MemWrite !== 1'b0 || PCWrite !== 1'b0) begin
            n_fail++; $display("FAIL sw_after_reset: got state=%0d MemWrite=%b PCWrite=%b, required 0/0/0",
                               state, MemWrite, PCWrite);
        end
        $display("test_reset_mid_stall done");
    endtask

    task automatic test_random();
        logic [6:0] ops[6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL};
        int retired = 0;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [6:0] o;
            logic f3;
            o  = ops[$urandom_range(0, 5)];
            f3 = 1'($urandom_range(0, 1));
            plan_instr(o);
            for (int i = 0; i < q_state.size(); i++) begin
                logic z;
                z = 1'($urandom_range(0, 1));
                tick(1'b0, o, f3, z, q_mr[i]);
                n_cmp++;
                if (state !== 4'(q_state[i])) begin
                    n_fail++; $display("FAIL rand_state[%0d.%0d]: got %0d, required %0d", n, i, state, q_state[i]);
                end
                n_cmp++;
                if (obs_ctrl !== exp_ctrl(q_state[i], q_mr[i], z, f3, 1'b0)) begin
                    n_fail++; $display("FAIL rand_ctrl[%0d.%0d]: got %b, required %b",
                                       n, i, obs_ctrl, exp_ctrl(q_state[i], q_mr[i], z, f3, 1'b0));
                end
                if (i == 0) begin
                    n_cmp++;
                    if (instret !== (CNT_EN ? 32'(retired) : 32'd0)) begin
                        n_fail++; $display("FAIL rand_instret[%0d]: got %0d, required %0d",
                                           n, instret, CNT_EN ? retired : 0);
                    end
                end
            end
            retired++;
            $display("instr %0d op=%b cycles=%0d", n, o, q_state.size());
        end
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (instret !== (CNT_EN ? 32'(retired) : 32'd0)) begin
            n_fail++; $display("FAIL rand_instret_final: got %0d, required %0d", instret, CNT_EN ? retired : 0);
        end
    endtask

    task automatic test_instret();
        logic [6:0] seq_op[4]  = '{OP_SW, OP_R, OP_B, OP_JAL};
        int         seq_lat[4] = '{4, 4, 3, 4};
        do_reset();
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < seq_lat[n]; c++) begin
                tick(1'b0, seq_op[n], 1'b0, 1'($urandom_range(0, 1)), 1'b1);
                if (c == 0) begin
                    n_cmp++;
                    if (state !== 4'd0) begin
                        n_fail++; $display("FAIL latency_start[%0d]: got state=%0d, required 0", n, state);
                    end
                end
            end
        end
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (instret !== (CNT_EN ? 32'd4 : 32'd0) || state !== 4'd0) begin
            n_fail++; $display("FAIL instret_four: got instret=%0d state=%0d, required instret=%0d state=0",
                               instret, state, CNT_EN ? 4 : 0);
        end
        do_reset();
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b0);
`ifdef INSTRET_COUNTER_EN
        dut.instret_reg = 32'hFFFF_FFFF;
`endif
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b1);
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b1);
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (instret !== (CNT_EN ? 32'hFFFF_FFFF : 32'd0)) begin
            n_fail++; $display("FAIL instret_preload_hold: got %h, required %h", instret, CNT_EN ? 32'hFFFF_FFFF : 32'd0);
        end
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b1);
        tick(1'b0, OP_R, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (instret !== 32'd0) begin
            n_fail++; $display("FAIL instret_wrap: got %h, required 0", instret);
        end
        $display("test_instret done");
    endtask

    initial begin
        reset = 1'b1; op = OP_R; funct3b0 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_trap();
        test_reset_mid_stall();
        test_random();
        test_instret();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  opcode of the instruction register.
REQ-005 funct3b0  input  1  funct3[0]: 0 = beq, 1 = bne.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory has completed the current access.
REQ-008 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ALUOp  output  2 each  datapath selects; ALUOp feeds alu_decoder.
REQ-010 illegal  output  1  unsupported opcode trapped.
REQ-011 state  output  4  current FSM state, for debug.
REQ-012 instret  output  32  retired-instruction count.

Function
REQ-013 The FSM SHALL have these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11.
REQ-014 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready; FETCH SHALL hold while mem_ready=0 and SHALL go to DECODE when mem_ready=1.
REQ-015 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BRANCH
- 1101111 -> JAL
- any other op -> TRAP
REQ-016 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state is MEMREAD when op[5]=0, MEMWRITE when op[5]=1.
REQ-017 MEMREAD: AdrSrc=1, ResultSrc=00; SHALL hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-019 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; SHALL stay asserted until mem_ready=1, then go to FETCH.
REQ-020 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both SHALL go to ALUWB.
REQ-021 ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
REQ-022 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=zero^funct3b0; next state FETCH.
REQ-023 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next state ALUWB.
REQ-024 TRAP: all enables 0, illegal=1; TRAP SHALL be sticky until reset.
REQ-025 Any output not listed for a state SHALL be 0.
REQ-026 Outputs SHALL be decoded combinationally from state (plus mem_ready, zero and funct3b0 where listed); the state register SHALL be the only sequential element apart from instret.
REQ-027 Instruction latency with mem_ready=1 throughout: lw 5 cycles; sw 4; R-type and I-type 4; branch 3; jal 4.
REQ-028 Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle to the instruction.

Reset
REQ-029 While reset=1 at a clock edge, state SHALL become FETCH and illegal SHALL become 0.
REQ-030 While reset=1, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0.
REQ-031 A reset asserted in any state, including mid-stall, SHALL abandon the instruction with no further write enables asserted.

Configuration
REQ-032 Macro INSTRET_COUNTER_EN defined: instret SHALL reset to 0 and increment by 1 (wrapping 0xFFFFFFFF->0) on each edge leaving MEMWB, ALUWB, MEMWRITE-with-mem_ready or BRANCH.
REQ-033 Macro INSTRET_COUNTER_EN undefined: instret SHALL be tied to 0 and no counter register SHALL exist.

Verification
REQ-034 op=0110011, mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in cycle 4; ALUOp=10 in cycle 3.
REQ-035 op=0000011, mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; RegWrite=1 once.
REQ-036 op=1100011: funct3b0=0 with zero=1 -> PCWrite=1 in BRANCH; funct3b0=1 with zero=1 -> PCWrite=0.
REQ-037 op=0000000 -> DECODE then TRAP; illegal=1 held for 10 cycles; reset -> state=0, illegal=0.
REQ-038 Reset asserted during MEMWRITE stall -> MemWrite=0 in the reset cycle, state=0 on the next cycle.
REQ-039 With INSTRET_COUNTER_EN: sw, add, beq, jal -> instret=4; preload 0xFFFFFFFF and retire one instruction -> instret=0.
